// File: rtl/dsp_dual_mac.sv
// Dual signed multiply sharing operand b in one wide product, with lane unpack, accumulate and saturation.
// Optional build macro DSP_DUAL_MAC_CHECK_EN adds a behavioural shadow checker (simulation only).
module dsp_dual_mac #(
    parameter string DSP_DEVICE = "DSPE2",
    parameter int    DW         = 8,
    parameter int    ACC_W      = 20
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_acc_en,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic signed [DW-1:0]    s_a,
    input  logic signed [DW-1:0]    s_d,
    input  logic signed [DW-1:0]    s_b,
    input  logic                    s_last,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic signed [ACC_W-1:0] m_ab,
    output logic signed [ACC_W-1:0] m_db,
    output logic                    m_sat
);
    localparam int SHIFT = (DSP_DEVICE == "DSPE2") ? 18 : 17;
    localparam int XW    = SHIFT + DW + 1;
    localparam int PW    = SHIFT + 2 * DW + 1;

    generate
        if (DSP_DEVICE != "DSPE2" && DSP_DEVICE != "DSPE1") begin : g_bad_device
            $error("dsp_dual_mac: DSP_DEVICE must be DSPE2 or DSPE1");
        end
        if (DW < 4 || DW > 8 || 2 * DW > SHIFT) begin : g_bad_dw
            $error("dsp_dual_mac: DW out of range for this device");
        end
        if (ACC_W < 2 * DW || ACC_W > 32) begin : g_bad_acc_w
            $error("dsp_dual_mac: ACC_W out of range");
        end
    endgenerate

    // Signed add with clamp to the ACC_W range; MSB of the result flags a clamp
    function automatic logic [ACC_W:0] sat_add(input logic signed [ACC_W-1:0] x,
                                               input logic signed [ACC_W-1:0] y);
        logic signed [ACC_W:0] s;
        s = (ACC_W+1)'(x) + (ACC_W+1)'(y);
        if (s[ACC_W] != s[ACC_W-1]) begin
            sat_add = {1'b1, s[ACC_W], {(ACC_W-1){~s[ACC_W]}}};
        end else begin
            sat_add = {1'b0, s[ACC_W-1:0]};
        end
    endfunction

    logic ce_s, accept_s, mode_s;
    logic grp_open_r, grp_acc_r;
    logic v1_r, first1_r, last1_r, v2_r, first2_r, last2_r, v3_r, first3_r, last3_r;
    logic signed [DW-1:0]    a1_r, d1_r, b1_r;
    logic signed [XW-1:0]    pre_s;
    logic signed [PW-1:0]    p_s, p2_r;
    logic signed [2*DW-1:0]  lo_s, hi_s, lo3_r, hi3_r;
    logic signed [ACC_W-1:0] acc_ab_r, acc_db_r, base_ab_s, base_db_s, ab_ext_s, db_ext_s;
    logic [ACC_W:0]          sum_ab_s, sum_db_s;
    logic                    sat_r, sat_base_s, sat_next_s;
    logic                    unused_s;

    assign ce_s     = ~m_valid | m_ready;
    assign s_ready  = ce_s;
    assign accept_s = s_valid & ce_s;
    assign mode_s   = grp_open_r ? grp_acc_r : cfg_acc_en;

    // Group tracking: the first accepted beat latches the mode; product mode closes every beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grp_open_r <= 1'b0;
            grp_acc_r  <= 1'b0;
        end else if (accept_s) begin
            grp_open_r <= mode_s & ~s_last;
            grp_acc_r  <= mode_s;
        end
    end

    // S1: operand capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_r <= 1'b0; first1_r <= 1'b0; last1_r <= 1'b0;
            a1_r <= {DW{1'b0}}; d1_r <= {DW{1'b0}}; b1_r <= {DW{1'b0}};
        end else if (ce_s) begin
            v1_r     <= s_valid;
            first1_r <= ~grp_open_r;
            last1_r  <= ~mode_s | s_last;
            a1_r     <= s_a;
            d1_r     <= s_d;
            b1_r     <= s_b;
        end
    end

    assign pre_s = $signed({a1_r[DW-1], a1_r, {SHIFT{1'b0}}}) + $signed({{(SHIFT+1){d1_r[DW-1]}}, d1_r});
    assign p_s   = $signed({{DW{pre_s[XW-1]}}, pre_s}) * $signed({{(SHIFT+DW+1){b1_r[DW-1]}}, b1_r});

    // S2: packed product
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_r <= 1'b0; first2_r <= 1'b0; last2_r <= 1'b0;
            p2_r <= {PW{1'b0}};
        end else if (ce_s) begin
            v2_r <= v1_r; first2_r <= first1_r; last2_r <= last1_r;
            p2_r <= p_s;
        end
    end

    // A negative d*b borrows one from the upper lane; add it back
    assign lo_s = p2_r[2*DW-1:0];
    assign hi_s = p2_r[SHIFT+2*DW-1:SHIFT] + {{(2*DW-1){1'b0}}, lo_s[2*DW-1]};
    assign unused_s = ^p2_r;

    // S3: unpacked lanes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3_r <= 1'b0; first3_r <= 1'b0; last3_r <= 1'b0;
            lo3_r <= {(2*DW){1'b0}}; hi3_r <= {(2*DW){1'b0}};
        end else if (ce_s) begin
            v3_r <= v2_r; first3_r <= first2_r; last3_r <= last2_r;
            lo3_r <= lo_s; hi3_r <= hi_s;
        end
    end

    // Accumulate step: the first beat of a group loads from zero
    always_comb begin
        ab_ext_s = ACC_W'(hi3_r);
        db_ext_s = ACC_W'(lo3_r);
        if (first3_r) begin
            base_ab_s  = {ACC_W{1'b0}};
            base_db_s  = {ACC_W{1'b0}};
            sat_base_s = 1'b0;
        end else begin
            base_ab_s  = acc_ab_r;
            base_db_s  = acc_db_r;
            sat_base_s = sat_r;
        end
        sum_ab_s   = sat_add(base_ab_s, ab_ext_s);
        sum_db_s   = sat_add(base_db_s, db_ext_s);
        sat_next_s = sat_base_s | sum_ab_s[ACC_W] | sum_db_s[ACC_W];
    end

    // S4: accumulators and registered result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_ab_r <= {ACC_W{1'b0}}; acc_db_r <= {ACC_W{1'b0}}; sat_r <= 1'b0;
            m_valid  <= 1'b0; m_ab <= {ACC_W{1'b0}}; m_db <= {ACC_W{1'b0}}; m_sat <= 1'b0;
        end else if (ce_s) begin
            m_valid <= v3_r & last3_r;
            if (v3_r) begin
                acc_ab_r <= sum_ab_s[ACC_W-1:0];
                acc_db_r <= sum_db_s[ACC_W-1:0];
                sat_r    <= sat_next_s;
                if (last3_r) begin
                    m_ab  <= sum_ab_s[ACC_W-1:0];
                    m_db  <= sum_db_s[ACC_W-1:0];
                    m_sat <= sat_next_s;
                end
            end
        end
    end

`ifdef DSP_DUAL_MAC_CHECK_EN
    localparam longint ACC_MAX = (longint'(1) <<< (ACC_W - 1)) - longint'(1);
    localparam longint ACC_MIN = -(longint'(1) <<< (ACC_W - 1));

    function automatic longint clamp(input longint v);
        if (v > ACC_MAX) begin
            clamp = ACC_MAX;
        end else if (v < ACC_MIN) begin
            clamp = ACC_MIN;
        end else begin
            clamp = v;
        end
    endfunction

    logic [31:0] err_cnt;
    logic        sh_open_r, sh_acc_r, sh_mode_s;
    logic [2:0]  sh_v_r, sh_first_r, sh_last_r;
    longint      sh_pab_r [3];
    longint      sh_pdb_r [3];
    longint      sh_sum_ab_r, sh_sum_db_r, sh_out_ab_r, sh_out_db_r;

    assign sh_mode_s = sh_open_r ? sh_acc_r : cfg_acc_en;

    // Shadow reference: direct multiplies and integer clamping, stalled by the same enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= 32'd0; sh_open_r <= 1'b0; sh_acc_r <= 1'b0;
            sh_v_r <= 3'd0; sh_first_r <= 3'd0; sh_last_r <= 3'd0;
            sh_pab_r <= '{default: 64'sd0}; sh_pdb_r <= '{default: 64'sd0};
            sh_sum_ab_r <= 64'sd0; sh_sum_db_r <= 64'sd0; sh_out_ab_r <= 64'sd0; sh_out_db_r <= 64'sd0;
        end else begin
            if (ce_s) begin
                if (accept_s) begin
                    sh_open_r <= sh_mode_s & ~s_last;
                    sh_acc_r  <= sh_mode_s;
                end
                sh_v_r     <= {sh_v_r[1:0], accept_s};
                sh_first_r <= {sh_first_r[1:0], ~sh_open_r};
                sh_last_r  <= {sh_last_r[1:0], ~sh_mode_s | s_last};
                sh_pab_r[0] <= longint'(s_a) * longint'(s_b);
                sh_pdb_r[0] <= longint'(s_d) * longint'(s_b);
                sh_pab_r[1] <= sh_pab_r[0]; sh_pab_r[2] <= sh_pab_r[1];
                sh_pdb_r[1] <= sh_pdb_r[0]; sh_pdb_r[2] <= sh_pdb_r[1];
                if (sh_v_r[2]) begin
                    sh_sum_ab_r <= clamp((sh_first_r[2] ? 64'sd0 : sh_sum_ab_r) + sh_pab_r[2]);
                    sh_sum_db_r <= clamp((sh_first_r[2] ? 64'sd0 : sh_sum_db_r) + sh_pdb_r[2]);
                    if (sh_last_r[2]) begin
                        sh_out_ab_r <= clamp((sh_first_r[2] ? 64'sd0 : sh_sum_ab_r) + sh_pab_r[2]);
                        sh_out_db_r <= clamp((sh_first_r[2] ? 64'sd0 : sh_sum_db_r) + sh_pdb_r[2]);
                    end
                end
            end
            if (m_valid && m_ready) begin
                if (longint'(m_ab) != sh_out_ab_r || longint'(m_db) != sh_out_db_r) begin
                    $error("dsp_dual_mac: result differs from shadow reference");
                    err_cnt <= err_cnt + 32'd1;
                end
            end
        end
    end
`endif
endmodule

// File: tb/tb_dsp_dual_mac.sv
// Bench for dsp_dual_mac: two instances (ACC_W=20 and ACC_W=16) on one stream, table vectors plus
// randomized traffic scored against a group-level arithmetic model.
module tb_dsp_dual_mac;
    logic clk = 1'b0, rst_n = 1'b0, cfg_acc_en = 1'b0, s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b1;
    logic signed [7:0] s_a = 8'sd0, s_d = 8'sd0, s_b = 8'sd0;
    logic s_ready20, m_valid20, m_sat20, s_ready16, m_valid16, m_sat16;
    logic signed [19:0] m_ab20, m_db20;
    logic signed [15:0] m_ab16, m_db16;

    int checks = 0, errors = 0, n_out = 0;

    typedef struct { longint ab20, db20, ab16, db16; bit sat20, sat16; } exp_t;
    exp_t exp_q[$];

    typedef struct { int a, d, b; bit last, acc, chk; int ab20, db20; bit sat20; int ab16, db16; bit sat16; } vec_t;
    vec_t vt[15];

    bit grp_open = 1'b0, grp_acc = 1'b0, sat20 = 1'b0, sat16 = 1'b0;
    longint sum_ab20, sum_db20, sum_ab16, sum_db16;

    dsp_dual_mac #(.DSP_DEVICE("DSPE2"), .DW(8), .ACC_W(20)) dut20 (
        .clk(clk), .rst_n(rst_n), .cfg_acc_en(cfg_acc_en), .s_valid(s_valid), .s_ready(s_ready20),
        .s_a(s_a), .s_d(s_d), .s_b(s_b), .s_last(s_last), .m_valid(m_valid20), .m_ready(m_ready),
        .m_ab(m_ab20), .m_db(m_db20), .m_sat(m_sat20));

    dsp_dual_mac #(.DSP_DEVICE("DSPE2"), .DW(8), .ACC_W(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .cfg_acc_en(cfg_acc_en), .s_valid(s_valid), .s_ready(s_ready16),
        .s_a(s_a), .s_d(s_d), .s_b(s_b), .s_last(s_last), .m_valid(m_valid16), .m_ready(m_ready),
        .m_ab(m_ab16), .m_db(m_db16), .m_sat(m_sat16));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic longint clampw(input longint v, input int w);
        longint hi, lo;
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -(longint'(1) <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // Group-level model: sum each lane over the group, clamping after every beat
    task automatic model_accept(input logic signed [7:0] a, d, b, input bit last, acc);
        longint pab, pdb, t;
        exp_t e;
        if (!grp_open) begin
            grp_acc = acc;
            sum_ab20 = 0; sum_db20 = 0; sum_ab16 = 0; sum_db16 = 0; sat20 = 0; sat16 = 0;
        end
        pab = longint'(a) * longint'(b);
        pdb = longint'(d) * longint'(b);
        t = sum_ab20 + pab; sum_ab20 = clampw(t, 20); if (sum_ab20 != t) sat20 = 1;
        t = sum_db20 + pdb; sum_db20 = clampw(t, 20); if (sum_db20 != t) sat20 = 1;
        t = sum_ab16 + pab; sum_ab16 = clampw(t, 16); if (sum_ab16 != t) sat16 = 1;
        t = sum_db16 + pdb; sum_db16 = clampw(t, 16); if (sum_db16 != t) sat16 = 1;
        if (!grp_acc || last) begin
            e.ab20 = sum_ab20; e.db20 = sum_db20; e.sat20 = sat20;
            e.ab16 = sum_ab16; e.db16 = sum_db16; e.sat16 = sat16;
            exp_q.push_back(e);
            grp_open = 0;
        end else begin
            grp_open = 1;
        end
    endtask

    function automatic logic signed [7:0] rnd8();
        logic [7:0] r;
        case ($urandom_range(0, 7))
            0:       r = 8'h80;
            1:       r = 8'h7f;
            default: r = 8'($urandom_range(0, 255));
        endcase
        return $signed(r);
    endfunction

    // Present one beat (called just after a rising edge) and hold it until accepted
    task automatic send(input int a, d, b, input bit last, acc);
        bit done;
        done = 1'b0;
        s_a = 8'(a); s_d = 8'(d); s_b = 8'(b); s_last = last; cfg_acc_en = acc; s_valid = 1'b1;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            if (s_ready20) begin
                model_accept(s_a, s_d, s_b, s_last, cfg_acc_en);
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        if (!done) chk("accept timeout", 0, 1);
        s_valid = 1'b0;
    endtask

    // Count falling edges after the accept edge until m_valid shows
    task automatic wait_valid(output int lat);
        lat = 0;
        for (int n = 1; n <= 12 && lat == 0; n++) begin
            @(negedge clk);
            if (m_valid20) lat = n;
        end
        if (lat == 0) chk("m_valid timeout", 0, 1);
    endtask

    // Monitor: score every handshake, hold outputs stable across stalls
    bit held = 1'b0;
    longint h_ab20, h_db20, h_ab16, h_db16;
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            chk("m_valid lanes agree", m_valid16, m_valid20);
            chk("s_ready lanes agree", s_ready16, s_ready20);
            if (m_valid20 && held) begin
                chk("stall m_ab20", m_ab20, h_ab20); chk("stall m_db20", m_db20, h_db20);
                chk("stall m_ab16", m_ab16, h_ab16); chk("stall m_db16", m_db16, h_db16);
            end
            if (m_valid20 && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("m_ab20", m_ab20, e.ab20); chk("m_db20", m_db20, e.db20); chk("m_sat20", m_sat20, e.sat20);
                    chk("m_ab16", m_ab16, e.ab16); chk("m_db16", m_db16, e.db16); chk("m_sat16", m_sat16, e.sat16);
                end
                n_out++;
                held = 1'b0;
            end else if (m_valid20) begin
                held = 1'b1;
                h_ab20 = m_ab20; h_db20 = m_db20; h_ab16 = m_ab16; h_db16 = m_db16;
            end else begin
                held = 1'b0;
            end
        end else begin
            held = 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, sent, n0;
        //        a     d     b   last acc chk  ab20    db20  s20  ab16    db16  s16
        vt[0]  = '{3,    -5,   7,    0, 0, 1, 21,     -35,   0, 21,     -35,   0};
        vt[1]  = '{5,    1,    -1,   0, 0, 1, -5,     -1,    0, -5,     -1,    0};
        vt[2]  = '{-128, -128, -128, 0, 0, 1, 16384,  16384, 0, 16384,  16384, 0};
        vt[3]  = '{1,    2,    3,    0, 1, 0, 0,      0,     0, 0,      0,     0};
        vt[4]  = '{4,    5,    6,    0, 1, 0, 0,      0,     0, 0,      0,     0};
        vt[5]  = '{-7,   8,    9,    0, 1, 0, 0,      0,     0, 0,      0,     0};
        vt[6]  = '{10,   -11,  12,   1, 1, 1, 84,     -24,   0, 84,     -24,   0};
        vt[7]  = '{-128, -128, -128, 0, 1, 0, 0,      0,     0, 0,      0,     0};
        vt[8]  = '{-128, -128, -128, 0, 1, 0, 0,      0,     0, 0,      0,     0};
        vt[9]  = '{-128, -128, -128, 1, 1, 1, 49152,  49152, 0, 32767,  32767, 1};
        vt[10] = '{1,    1,    1,    1, 1, 1, 1,      1,     0, 1,      1,     0};
        vt[11] = '{2,    3,    4,    0, 0, 1, 8,      12,    0, 8,      12,    0};
        vt[12] = '{-128, 127,  127,  0, 0, 1, -16256, 16129, 0, -16256, 16129, 0};
        vt[13] = '{2,    2,    2,    0, 1, 0, 0,      0,     0, 0,      0,     0};
        vt[14] = '{3,    3,    3,    1, 0, 1, 13,     13,    0, 13,     13,    0};

        #12;
        chk("reset m_valid", m_valid20, 0); chk("reset m_ab", m_ab20, 0); chk("reset m_db", m_db20, 0);
        chk("reset m_sat", m_sat16, 0); chk("reset s_ready", s_ready20, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 15; i++) begin
            send(vt[i].a, vt[i].d, vt[i].b, vt[i].last, vt[i].acc);
            if (vt[i].chk) begin
                wait_valid(lat);
                if (i == 0) chk("latency", lat, 4);
                chk("tbl ab20", m_ab20, vt[i].ab20); chk("tbl db20", m_db20, vt[i].db20);
                chk("tbl sat20", m_sat20, vt[i].sat20);
                chk("tbl ab16", m_ab16, vt[i].ab16); chk("tbl db16", m_db16, vt[i].db16);
                chk("tbl sat16", m_sat16, vt[i].sat16);
                @(posedge clk); #1;
            end
        end

        // Full-rate product stream with a 5-cycle downstream stall
        sent = 0; n0 = n_out;
        for (int cyc = 0; cyc < 100 && sent < 10; cyc++) begin
            s_valid = 1'b1; cfg_acc_en = 1'b0; s_last = 1'($urandom_range(0, 1));
            s_a = rnd8(); s_d = rnd8(); s_b = rnd8();
            m_ready = !(cyc >= 5 && cyc < 10);
            @(negedge clk);
            if (s_valid && s_ready20) begin
                model_accept(s_a, s_d, s_b, s_last, cfg_acc_en);
                sent++;
            end
            @(posedge clk); #1;
        end
        s_valid = 1'b0; m_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("backpressure result count", n_out - n0, 10);

        // Reset in the middle of an open accumulate group
        send(1, 1, 1, 0, 1);
        send(1, 1, 1, 0, 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        exp_q.delete(); grp_open = 1'b0;
        #1;
        chk("mid reset m_valid", m_valid20, 0); chk("mid reset m_ab", m_ab20, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(2, 3, 4, 1, 1);
        wait_valid(lat);
        chk("post reset ab", m_ab20, 8); chk("post reset db", m_db20, 12); chk("post reset sat", m_sat20, 0);
        @(posedge clk); #1;

        // Random traffic: valid, ready, last and mode all vary
        for (int cyc = 0; cyc < 600; cyc++) begin
            s_valid = ($urandom_range(0, 3) != 0);
            s_last = ($urandom_range(0, 3) == 0);
            cfg_acc_en = 1'($urandom_range(0, 1));
            m_ready = ($urandom_range(0, 3) != 0);
            s_a = rnd8(); s_d = rnd8(); s_b = rnd8();
            @(negedge clk);
            if (s_valid && s_ready20) model_accept(s_a, s_d, s_b, s_last, cfg_acc_en);
            @(posedge clk); #1;
        end
        s_valid = 1'b0; m_ready = 1'b1;
        send(0, 0, 0, 1, 1);
        repeat (20) @(posedge clk);
        #1;
        chk("outstanding results", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
